// File: rtl/sdram_wr_pkg.sv
// Shared types and constants for the SDRAM write-burst front end.
// Address layout is {bank[1:0], row[12:0], col[8:0]}.
package sdram_wr_pkg;

  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 16;
  localparam int BLEN_W   = 10;

  localparam int COL_LSB  = 0;
  localparam int ROW_LSB  = 9;
  localparam int BANK_LSB = 22;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_REQ,
    S_BURST,
    S_ADV
  } state_t;

  function automatic logic [ADDR_W-1:0] frame_base(
    input logic [ADDR_W-1:0] base,
    input logic              sel
  );
    logic [ADDR_W-1:0] flip;
    flip = '0;
    flip[BANK_LSB] = sel;
    return base ^ flip;
  endfunction

endpackage

// File: rtl/sdram_wr_burst_gen_fifo.sv
// Synchronous FIFO with registered read data and synchronous clear.
// A write in the clear cycle becomes the first entry after the clear.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      fill
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (fill == FULL_CNT);
  assign empty = (fill == '0);
  assign do_wr = wr && (!full || clr);
  assign do_rd = rd && !empty && !clr;

  always_ff @(posedge clk) begin
    if (do_wr) mem[clr ? '0 : wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
      dout <= '0;
    end else if (clr) begin
      rptr <= '0;
      wptr <= AW'(do_wr);
      fill <= (AW+1)'(do_wr);
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) begin
        rptr <= rptr + AW'(1);
        dout <= mem[rptr];
      end
      fill <= fill + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

endmodule

// File: rtl/sdram_wr_burst_gen.sv
// Buffers a pixel stream and issues fixed-length SDRAM write bursts.
// Define SDRAM_WR_PINGPONG_EN for two alternating frame buffers.
module sdram_wr_burst_gen
  import sdram_wr_pkg::*;
#(
  parameter int          BURST_LEN   = 256,
  parameter int          FIFO_DEPTH  = 1024,
  parameter int          FRAME_WORDS = 307200,
  parameter logic [23:0] BASE_ADDR   = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_sys_addr,
  output logic [BLEN_W-1:0] br_length,
  output logic [DATA_W-1:0] wdata,
  output logic              fifo_ovf,
  output logic              frame_done
`ifdef SDRAM_WR_PINGPONG_EN
  ,
  output logic              wr_buf_sel
`endif
);

`ifdef SDRAM_WR_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [FAW:0]        BLEN_FILL = (FAW+1)'(BURST_LEN);
  localparam logic [BLEN_W-1:0]   BLEN      = BLEN_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0]   WSTEP     = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0]   WFRAME    = ADDR_W'(FRAME_WORDS);

  state_t            state;
  state_t            state_n;
  logic [BLEN_W-1:0] ack_cnt;
  logic [BLEN_W-1:0] ack_inc;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] word_inc;
  logic              fs_pend;
  logic              buf_sel;
  logic              sel_nx;
  logic              in_burst;
  logic              pop;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FAW:0]      fill;

  assign br_length = BLEN;
  assign in_burst  = (state == S_REQ) || (state == S_BURST);
  assign wr_req    = in_burst;
  assign pop       = wr_ack && in_burst;
  assign flush     = ((state == S_IDLE) || (state == S_WAIT_INIT))
                     && (frame_start || fs_pend);
  assign ack_inc   = ack_cnt + BLEN_W'(1);
  assign word_inc  = word_cnt + WSTEP;
  assign sel_nx    = buf_sel ^ PP;

`ifdef SDRAM_WR_PINGPONG_EN
  assign wr_buf_sel = buf_sel;
`endif

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .wr    (pix_valid),
    .rd    (pop),
    .din   (pix_data),
    .dout  (wdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_WAIT_INIT: if (init_done) state_n = S_IDLE;
      S_IDLE:      if (!flush && fill >= BLEN_FILL) state_n = S_REQ;
      S_REQ:       if (wr_ack) state_n = S_BURST;
      S_BURST:     if (wr_ack && ack_inc == BLEN) state_n = S_ADV;
      S_ADV:       state_n = S_IDLE;
      default:     state_n = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_WAIT_INIT;
      ack_cnt     <= '0;
      word_cnt    <= '0;
      wr_sys_addr <= BASE_ADDR;
      fs_pend     <= 1'b0;
      buf_sel     <= 1'b0;
      fifo_ovf    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= 1'b0;
      // a pixel arriving with a flush is kept, so it cannot overflow
      if (pix_valid && fifo_full && !flush) fifo_ovf <= 1'b1;

      if (flush) fs_pend <= 1'b0;
      else if (frame_start) fs_pend <= 1'b1;

      if (state == S_REQ && wr_ack) ack_cnt <= BLEN_W'(1);
      else if (state == S_BURST && wr_ack) ack_cnt <= ack_inc;

      if (flush) begin
        word_cnt    <= '0;
        buf_sel     <= sel_nx;
        wr_sys_addr <= frame_base(BASE_ADDR, sel_nx);
      end else if (state == S_ADV) begin
        if (word_inc == WFRAME) begin
          word_cnt    <= '0;
          frame_done  <= 1'b1;
          buf_sel     <= sel_nx;
          wr_sys_addr <= frame_base(BASE_ADDR, sel_nx);
        end else begin
          word_cnt    <= word_inc;
          wr_sys_addr <= wr_sys_addr + WSTEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && pop) assert (!fifo_empty);
  end

endmodule

// File: tb/tb_sdram_wr_burst_gen.sv
// Directed bench for sdram_wr_burst_gen: init gating, bursts, frame
// wrap, overflow, immediate and deferred frame_start flushes.
module tb_sdram_wr_burst_gen;

`ifdef SDRAM_WR_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        frame_start;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        wr_req;
  logic        wr_ack;
  logic [23:0] wr_sys_addr;
  logic [9:0]  br_length;
  logic [15:0] wdata;
  logic        fifo_ovf;
  logic        frame_done;
`ifdef SDRAM_WR_PINGPONG_EN
  logic        wr_buf_sel;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit sel_exp = 1'b0;

  always #5 clk = ~clk;

  sdram_wr_burst_gen #(
    .BURST_LEN   (256),
    .FIFO_DEPTH  (512),
    .FRAME_WORDS (1024),
    .BASE_ADDR   (24'h000000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .wr_req      (wr_req),
    .wr_ack      (wr_ack),
    .wr_sys_addr (wr_sys_addr),
    .br_length   (br_length),
    .wdata       (wdata),
    .fifo_ovf    (fifo_ovf),
    .frame_done  (frame_done)
`ifdef SDRAM_WR_PINGPONG_EN
    ,
    .wr_buf_sel  (wr_buf_sel)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] base_of(input bit s);
    return (PP && s) ? 24'h400000 : 24'h000000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(start + i);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic burst(input logic [23:0] addr, input int dstart,
                       input int stream, input int fs_at,
                       input bit exp_done, input int wait_max);
    int n;
    int bad;
    n = 0;
    while (!wr_req && n < wait_max) begin
      tick();
      n++;
    end
    check("req_rise", wr_req, 1'b1);
    check("addr", wr_sys_addr, addr);
    check("br_length", br_length, 10'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      wr_ack      = 1'b1;
      frame_start = (i == fs_at);
      if (stream >= 0) begin
        pix_valid = 1'b1;
        pix_data  = 16'(stream + i);
      end
      tick();
      if (wdata !== 16'(dstart + i) && bad < 4) begin
        bad++;
        check("wdata", wdata, 16'(dstart + i));
      end
    end
    wr_ack      = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    check("burst_data_ok", bad, 0);
    check("req_fall", wr_req, 1'b0);
    tick();
    check("frame_done", frame_done, exp_done);
    tick();
    check("frame_done_clr", frame_done, 1'b0);
  endtask

  initial begin
    bit seen;
    rst_n       = 1'b0;
    init_done   = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = '0;
    wr_ack      = 1'b0;
    repeat (3) tick();
    check("rst_req", wr_req, 1'b0);
    check("rst_addr", wr_sys_addr, 24'h000000);
    check("rst_wdata", wdata, 16'h0000);
    check("rst_ovf", fifo_ovf, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_blen", br_length, 10'd256);
    rst_n = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(i);
      tick();
      seen |= wr_req;
    end
    pix_valid = 1'b0;
    repeat (10) begin
      tick();
      seen |= wr_req;
    end
    check("no_req_before_init", seen, 1'b0);
    init_done = 1'b1;

    burst(24'h000000, 0, -1, -1, 1'b0, 8);
    push(300, 468);
    burst(24'h000100, 256, -1, -1, 1'b0, 8);
    burst(24'h000200, 512, -1, -1, 1'b0, 4);
    check("ovf_still_clear", fifo_ovf, 1'b0);

    push(768, 256);
    burst(24'h000300, 768, 1024, -1, 1'b1, 8);
    sel_exp = ~sel_exp;
`ifdef SDRAM_WR_PINGPONG_EN
    check("buf_sel_wrap", wr_buf_sel, 1'b1);
`endif
    burst(base_of(sel_exp), 1024, -1, -1, 1'b0, 2);

    push(2000, 600);
    check("ovf_set", fifo_ovf, 1'b1);
    burst(base_of(sel_exp) + 24'h100, 2000, -1, -1, 1'b0, 8);
    burst(base_of(sel_exp) + 24'h200, 2256, -1, -1, 1'b0, 4);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= wr_req;
    end
    check("dropped_absent", seen, 1'b0);

    push(2800, 100);
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_data    = 16'd2900;
    tick();
    frame_start = 1'b0;
    sel_exp = ~sel_exp;
    check("flush_addr", wr_sys_addr, base_of(sel_exp));
    push(2901, 299);
    burst(base_of(sel_exp), 2900, -1, 99, 1'b0, 8);
    sel_exp = ~sel_exp;
    tick();
    check("pend_flush_addr", wr_sys_addr, base_of(sel_exp));
    push(4000, 256);
    burst(base_of(sel_exp), 4000, -1, -1, 1'b0, 8);
    check("ovf_sticky", fifo_ovf, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
